// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding and digit-adjust constants for bin2bcd_seq
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, OP = 2'b01, DONE = 2'b10} state_t;
  localparam int DIGIT_W = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD = 3;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/result bundle between a binary source and bin2bcd_seq
interface bin2bcd_seq_if import bin2bcd_pkg::*; #(parameter int WIDTH = 8, parameter int DIGITS = 3);
  logic start;
  logic [WIDTH-1:0] bin;
  logic ready;
  logic done_tick;
  logic [DIGIT_W*DIGITS-1:0] bcd;
  logic overflow;
  logic [DIGITS-1:0] blank;
  modport master(output start, bin, input ready, done_tick, bcd, overflow, blank);
  modport slave(input start, bin, output ready, done_tick, bcd, overflow, blank);
endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: one BCD digit of the shift-and-add-3 step (>= 5 gets +3, mod 16)
module bcd_digit_adj import bin2bcd_pkg::*; (
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  always_comb q = (d >= DIGIT_W'(ADJ_THRESH)) ? d + DIGIT_W'(ADJ_ADD) : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one bit per clock; BIN2BCD_LEADING_BLANK_EN enables the leading-zero blank mask
module bin2bcd_seq import bin2bcd_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic clr,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int NW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0] dig_q, dig_d, adj, bcd_q, bcd_d;
  logic ovf_q, ovf_d, ovo_q, ovo_d;
  logic [NW-1:0] n_q, n_d;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(dig_q[i*DIGIT_W +: DIGIT_W]), .q(adj[i*DIGIT_W +: DIGIT_W]));
  end
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    dig_d = dig_q;
    ovf_d = ovf_q;
    n_d = n_q;
    bcd_d = bcd_q;
    ovo_d = ovo_q;
    if (state_q == IDLE && bus.start) begin
      sh_d = bus.bin;
      dig_d = '0;
      ovf_d = 1'b0;
      n_d = NW'(WIDTH);
      state_d = OP;
    end else if (state_q == OP) begin
      sh_d = sh_q << 1;
      dig_d = {adj[BW-2:0], sh_q[WIDTH-1]};
      ovf_d = ovf_q | adj[BW-1];
      n_d = n_q - NW'(1);
      // last shift: publish the freshly shifted digits together with DONE
      if (n_q == NW'(1)) begin
        state_d = DONE;
        bcd_d = dig_d;
        ovo_d = ovf_d;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      sh_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
      n_q <= '0;
      bcd_q <= '0;
      ovo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      dig_q <= dig_d;
      ovf_q <= ovf_d;
      n_q <= n_d;
      bcd_q <= bcd_d;
      ovo_q <= ovo_d;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.done_tick = state_q == DONE;
  assign bus.bcd = bcd_q;
  assign bus.overflow = ovo_q;
`ifdef BIN2BCD_LEADING_BLANK_EN
  assign bus.blank[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign bus.blank[i] = bcd_q[BW-1:i*DIGIT_W] == '0;
  end
`else
  assign bus.blank = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (8-bit and 10-bit instances, 3 digits)
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) b8();
  bin2bcd_seq_if #(.WIDTH(10), .DIGITS(3)) b10();
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (.clk(clk), .clr(clr), .bus(b8));
  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut10 (.clk(clk), .clr(clr), .bus(b10));

  typedef struct packed {
    logic [11:0] bcd;
    logic ovf;
    logic [2:0] blank;
  } exp_t;

`ifdef BIN2BCD_LEADING_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  exp_t q8[$];
  exp_t q10[$];
  exp_t e8, e10;
  int checks = 0, errors = 0, cyc = 0;
  int acc8 = 0, done8 = 0, done10 = 0, last8 = -1;
  bit sweep = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [2:0] blk(input logic [2:0] b);
    return BLK ? b : 3'b000;
  endfunction

  function automatic exp_t mk(input logic [11:0] bcd, input logic ovf, input logic [2:0] b);
    exp_t e;
    e.bcd = bcd;
    e.ovf = ovf;
    e.blank = blk(b);
    return e;
  endfunction

  // decimal reference: digits by division, blank from leading zero digits
  function automatic exp_t model(input int v);
    int m;
    exp_t e;
    m = v % 1000;
    e.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    e.ovf = v >= 1000;
    e.blank = blk({e.bcd[11:8] == 4'd0, e.bcd[11:4] == 8'd0, 1'b0});
    return e;
  endfunction

  always @(negedge clk) begin
    if (b8.done_tick) begin
      done8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8 unexpected done_tick: got bcd %h expected no done", b8.bcd);
      end else begin
        e8 = q8.pop_front();
        chk("dut8 bcd", 32'(b8.bcd), 32'(e8.bcd));
        chk("dut8 overflow", 32'(b8.overflow), 32'(e8.ovf));
        chk("dut8 blank", 32'(b8.blank), 32'(e8.blank));
        chk("dut8 ready during done", 32'(b8.ready), 0);
      end
      if (sweep && last8 >= 0) chk("sweep period", cyc - last8, 10);
      last8 = cyc;
    end
    if (b10.done_tick) begin
      done10++;
      if (q10.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut10 unexpected done_tick: got bcd %h expected no done", b10.bcd);
      end else begin
        e10 = q10.pop_front();
        chk("dut10 bcd", 32'(b10.bcd), 32'(e10.bcd));
        chk("dut10 overflow", 32'(b10.overflow), 32'(e10.ovf));
        chk("dut10 blank", 32'(b10.blank), 32'(e10.blank));
      end
    end
  end

  task automatic wait_ready8();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = b8.ready;
    end
    if (!ok) chk("dut8 ready timeout", 0, 1);
  endtask

  task automatic wait_done8(input int target);
    for (int i = 0; i < 40 && done8 < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk("dut8 done count", done8, target);
  endtask

  task automatic issue8(input logic [7:0] v, input exp_t e);
    wait_ready8();
    b8.start = 1'b1;
    b8.bin = v;
    @(posedge clk);
    q8.push_back(e);
    @(negedge clk);
    acc8 = cyc;
    b8.start = 1'b0;
    b8.bin = ~v;
    chk("dut8 ready after accept", 32'(b8.ready), 0);
  endtask

  task automatic run8(input logic [7:0] v, input exp_t e);
    int target;
    target = done8 + 1;
    issue8(v, e);
    wait_done8(target);
    chk("dut8 latency", last8 - acc8, 8);
    @(negedge clk);
    chk("dut8 ready after done", 32'(b8.ready), 1);
  endtask

  task automatic run10(input logic [9:0] v, input exp_t e);
    int target;
    target = done10 + 1;
    b10.start = 1'b1;
    b10.bin = v;
    @(posedge clk);
    q10.push_back(e);
    @(negedge clk);
    b10.start = 1'b0;
    b10.bin = ~v;
    for (int i = 0; i < 40 && done10 < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk("dut10 done count", done10, target);
    @(negedge clk);
  endtask

  initial begin
    int target;
    b8.start = 1'b0;
    b8.bin = '0;
    b10.start = 1'b0;
    b10.bin = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("reset ready", 32'(b8.ready), 1);
    chk("reset done_tick", 32'(b8.done_tick), 0);
    chk("reset bcd", 32'(b8.bcd), 0);
    chk("reset overflow", 32'(b8.overflow), 0);
    chk("reset blank", 32'(b8.blank), 32'(blk(3'b110)));
    chk("reset dut10 ready", 32'(b10.ready), 1);

    run8(8'd255, mk(12'h255, 1'b0, 3'b000));
    run8(8'd0, mk(12'h000, 1'b0, 3'b110));
    run8(8'd7, mk(12'h007, 1'b0, 3'b110));
    run8(8'd42, mk(12'h042, 1'b0, 3'b100));

    // a start pulse during OP must be dropped, not queued
    target = done8 + 1;
    issue8(8'd99, mk(12'h099, 1'b0, 3'b100));
    repeat (2) @(negedge clk);
    b8.start = 1'b1;
    b8.bin = 8'd200;
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8(target);
    repeat (15) @(negedge clk);
    chk("ignored start single done", done8, target);

    // clear four cycles into a conversion of 128
    target = done8;
    wait_ready8();
    b8.start = 1'b1;
    b8.bin = 8'd128;
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr bcd", 32'(b8.bcd), 0);
    chk("clr ready", 32'(b8.ready), 1);
    chk("clr overflow", 32'(b8.overflow), 0);
    chk("clr blank", 32'(b8.blank), 32'(blk(3'b110)));
    repeat (15) @(negedge clk);
    chk("clr no done", done8, target);
    run8(8'd17, mk(12'h017, 1'b0, 3'b100));

    run10(10'd1023, mk(12'h023, 1'b1, 3'b100));
    run10(10'd999, mk(12'h999, 1'b0, 3'b000));

    // back-to-back sweep with start held high
    sweep = 1'b1;
    last8 = -1;
    target = done8 + 256;
    for (int v = 0; v < 256; v++) begin
      wait_ready8();
      b8.start = 1'b1;
      b8.bin = 8'(v);
      @(posedge clk);
      q8.push_back(model(v));
    end
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8(target);
    sweep = 1'b0;
    chk("dut8 queue drained", q8.size(), 0);
    chk("dut10 queue drained", q10.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
